mux_rr_reg: RTL and testbench

//   Parametrised N-channel, WIDTH-bit registered multiplexer for the DLX datapath and

---
 rtl/mux_rr_reg.sv | 116 +++++++++++
 tb/tb_mux_rr_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_reg
// Description : N-channel registered multiplexer with valid/ready flow control.
//               A channel is chosen either by an explicit select (fixed mode)
//               or by round-robin arbitration. The chosen word goes into a
//               one-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_reg #(
    parameter  int WIDTH   = 32,
    parameter  int NCH     = 4,
    parameter  int RR_MODE = 1,
    localparam int SELW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    localparam logic [SELW-1:0] C_LAST_RST = SELW'(NCH - 1);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SELW-1:0]  r_ch;
    logic [SELW-1:0]  r_last;

    logic             w_load;
    logic             w_xfer;
    logic [SELW-1:0]  w_grant;
    logic             w_grant_vld;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_unused;

    // sel is ignored in round-robin mode and the pointer in fixed mode
    assign w_unused = ^{sel, r_last};

    // The output register can accept a word when empty or draining this cycle
    assign w_load = !r_valid || out_ready;
    assign w_xfer = w_load && w_grant_vld;

    // Grant selection: rotating priority starting after the last grant, or explicit select
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        if (RR_MODE != 0) begin
            // Walk from the lowest priority to the highest so the nearest valid
            // channel after the last grant is the one that finally sticks.
            for (int i = NCH; i >= 1; i--) begin
                for (int c = 0; c < NCH; c++) begin
                    if (in_valid[c] && (((int'(r_last) + i) % NCH) == c)) begin
                        w_grant = SELW'(c);
                    end
                end
            end
            w_grant_vld = |in_valid;
        end else begin
            w_grant = sel;
            // An out-of-range select matches no channel and so never grants
            for (int c = 0; c < NCH; c++) begin
                if (sel == SELW'(c)) begin
                    w_grant_vld = in_valid[c];
                end
            end
        end
    end

    // Data path multiplexer for the granted channel
    always_comb begin
        w_mux_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_grant == SELW'(c)) begin
                w_mux_data = in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Only the granted channel sees ready, and only when a transfer happens
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ready
            assign in_ready[c] = w_xfer && (w_grant == SELW'(c));
        end
    endgenerate

    // Output register and last-grant pointer; the pointer only moves on a transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_last  <= C_LAST_RST;
        end else if (w_load) begin
            if (w_grant_vld) begin
                r_valid <= 1'b1;
                r_data  <= w_mux_data;
                r_ch    <= w_grant;
                r_last  <= w_grant;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_ch    = r_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_reg
// Description : Scoreboard bench for mux_rr_reg. Three instances share the
//               stimulus: round-robin NCH=4, round-robin NCH=3, fixed NCH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [1:0]   sel;
    logic         out_ready;

    wire [31:0] od  [3];
    wire        ov  [3];
    wire [1:0]  oc  [3];
    wire [3:0]  rdy [3];
    wire [2:0]  rdy1;

    assign rdy[1] = {1'b0, rdy1};

    always #5 clk = ~clk;

    mux_rr_reg #(.WIDTH(32), .NCH(4), .RR_MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .sel(sel), .out_data(od[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_ch(oc[0])
    );

    mux_rr_reg #(.WIDTH(32), .NCH(3), .RR_MODE(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]),
        .in_ready(rdy1), .sel(sel), .out_data(od[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_ch(oc[1])
    );

    mux_rr_reg #(.WIDTH(32), .NCH(4), .RR_MODE(0)) u_fix4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[2]), .sel(sel), .out_data(od[2]), .out_valid(ov[2]),
        .out_ready(out_ready), .out_ch(oc[2])
    );

    // Reference model state, one slot per instance
    int          m_last [3];
    bit          m_valid [3];
    bit          exp_new [3];
    logic [39:0] hold [3];
    logic [39:0] q [3][$];
    int          ch_log [3][$];
    bit          in_reset = 1'b1;
    int          checks = 0;
    int          errors = 0;

    function automatic int nch(input int k);
        return (k == 1) ? 3 : 4;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_last[k]  = nch(k) - 1;
            m_valid[k] = 1'b0;
            exp_new[k] = 1'b0;
            hold[k]    = '0;
            q[k].delete();
            ch_log[k].delete();
        end
    endtask

    // Apply one cycle of stimulus (called at a falling edge), predict, then wait
    task automatic drive(input logic [3:0] v, input logic [1:0] s, input logic r, input bit rnd);
        in_valid  = v;
        sel       = s;
        out_ready = r;
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = rnd ? $urandom : (32'hA0 + i);
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            int         n;
            int         g;
            int         c;
            bit         gv;
            bit         load;
            logic [3:0] er;
            n  = nch(k);
            g  = 0;
            gv = 1'b0;
            if (k != 2) begin
                for (int i = 1; i <= n; i++) begin
                    c = (m_last[k] + i) % n;
                    if (!gv && v[c[1:0]]) begin
                        g  = c;
                        gv = 1'b1;
                    end
                end
            end else begin
                g  = int'(s);
                gv = (g < n) && v[s];
            end
            load = !m_valid[k] || r;
            er   = (load && gv) ? 4'(1 << g) : 4'b0000;
            chk($sformatf("in_ready dut%0d", k), 64'(rdy[k]), 64'(er));
            exp_new[k] = load;
            if (load) begin
                if (gv) begin
                    q[k].push_back({8'(g), in_data[g*32 +: 32]});
                    m_last[k] = g;
                end
                m_valid[k] = gv;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_reset  = 1'b1;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        sel       = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset out_valid dut%0d", k), 64'(ov[k]), 64'(0));
            chk($sformatf("reset out_data dut%0d", k), 64'(od[k]), 64'(0));
            chk($sformatf("reset out_ch dut%0d", k), 64'(oc[k]), 64'(0));
        end
        model_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        in_reset = 1'b0;
    endtask

    // Compare the first n logged channels (list given as hex nibbles, first entry leftmost)
    task automatic check_log(input int k, input int n, input logic [31:0] lst);
        int act;
        for (int i = 0; i < n; i++) begin
            act = (i < ch_log[k].size()) ? ch_log[k][i] : -1;
            chk($sformatf("grant seq dut%0d #%0d", k, i), 64'(act), 64'(lst[4*(n-1-i) +: 4]));
        end
    endtask

    // Monitor: after each edge, pop and compare a newly loaded word, or check a held word
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!in_reset) begin
                for (int k = 0; k < 3; k++) begin
                    if (exp_new[k]) begin
                        chk($sformatf("out_valid dut%0d", k), 64'(ov[k]), 64'(q[k].size() != 0));
                        if (q[k].size() != 0) begin
                            hold[k] = q[k].pop_front();
                            chk($sformatf("out_data dut%0d", k), 64'(od[k]), 64'(hold[k][31:0]));
                            chk($sformatf("out_ch dut%0d", k), 64'(oc[k]), 64'(hold[k][39:32]));
                            ch_log[k].push_back(int'(oc[k]));
                        end
                    end else begin
                        chk($sformatf("stall out_valid dut%0d", k), 64'(ov[k]), 64'(1));
                        chk($sformatf("stall out_data dut%0d", k), 64'(od[k]), 64'(hold[k][31:0]));
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        sel       = '0;
        out_ready = 1'b0;
        in_data   = '0;
        @(negedge clk);
        do_reset();

        // Fill the registers, then reset while words are held
        repeat (3) drive(4'b1111, 2'd0, 1'b1, 1'b0);
        do_reset();

        // Round-robin over all channels, wrap for NCH=4 and NCH=3
        repeat (6) drive(4'b1111, 2'd0, 1'b1, 1'b0);
        check_log(0, 5, 32'h01230);
        check_log(1, 5, 32'h01201);
        check_log(2, 3, 32'h000);

        // Backpressure: hold the second word for three cycles, then resume
        do_reset();
        repeat (2) drive(4'b1111, 2'd0, 1'b1, 1'b0);
        repeat (3) drive(4'b1111, 2'd0, 1'b0, 1'b0);
        drive(4'b1111, 2'd0, 1'b1, 1'b0);
        check_log(0, 3, 32'h012);

        // Sparse round-robin starting from last grant = NCH-1
        do_reset();
        repeat (4) drive(4'b1010, 2'd0, 1'b1, 1'b0);
        check_log(0, 4, 32'h1313);
        check_log(1, 4, 32'h1111);

        // Fixed select: selected channel goes idle, then becomes valid
        do_reset();
        drive(4'b1111, 2'd1, 1'b1, 1'b0);
        repeat (2) drive(4'b1011, 2'd2, 1'b1, 1'b0);
        drive(4'b1111, 2'd2, 1'b1, 1'b0);
        check_log(2, 2, 32'h12);

        // Randomised traffic against the reference model
        do_reset();
        for (int t = 0; t < 10000; t++) begin
            drive(4'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
        end
        repeat (3) drive(4'b0000, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("leftover words dut%0d", k), 64'(q[k].size()), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
